// File: rtl/axi_pkg.sv
// Shared types and constants for the two-master AXI-lite arbiter.
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IFU_AR,
    IFU_R,
    LSU_AR,
    LSU_R,
    LSU_W,
    LSU_B
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/axi_arbiter_if.sv
// Boundary bundle of the arbiter: IFU and LSU master channels plus the crossbar upstream port.
interface axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ifu_arvalid;
  logic              ifu_arready;
  logic [ADDR_W-1:0] ifu_araddr;
  logic              ifu_rvalid;
  logic              ifu_rready;
  logic [1:0]        ifu_rresp;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_arvalid;
  logic              lsu_arready;
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_rvalid;
  logic              lsu_rready;
  logic [1:0]        lsu_rresp;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_awvalid;
  logic              lsu_awready;
  logic [ADDR_W-1:0] lsu_awaddr;
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic [DATA_W-1:0] lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wstrb;
  logic              lsu_bvalid;
  logic              lsu_bready;
  logic [1:0]        lsu_bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  // Arbiter view: slave to both masters, master toward the crossbar.
  modport slave (
    input  ifu_arvalid, ifu_araddr, ifu_rready,
    output ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata,
    input  lsu_arvalid, lsu_araddr, lsu_rready,
    input  lsu_awvalid, lsu_awaddr, lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_bready,
    output lsu_arready, lsu_rvalid, lsu_rresp, lsu_rdata,
    output lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp
  );

  // Environment view: the two masters and the crossbar together.
  modport master (
    output ifu_arvalid, ifu_araddr, ifu_rready,
    input  ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata,
    output lsu_arvalid, lsu_araddr, lsu_rready,
    output lsu_awvalid, lsu_awaddr, lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_bready,
    input  lsu_arready, lsu_rvalid, lsu_rresp, lsu_rdata,
    input  lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/axi_arb_wdog.sv
// Response watchdog: saturating counter that flags the cycle it sits at TIMEOUT-1 while enabled.
module axi_arb_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // TIMEOUT of zero keeps the counter parked at zero and never fires.
  assign expire_o = (TIMEOUT != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/axi_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI-lite arbiter, one transaction in flight, round-robin grant.
module axi_arbiter
  import axi_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset_n,
  axi_arbiter_if.slave  bus,
  output logic          timeout_err
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  arb_state_e state_q;
  logic       last_grant_q;
  logic       aw_done_q;
  logic       w_done_q;
  logic       forced_q;
  logic       timeout_err_q;

  logic ifu_req, lsu_req;
  logic aw_hs, w_hs;
  logic wait_st, slv_valid, own_ready;
  logic wd_expire;

  assign ifu_req = bus.ifu_arvalid;
  assign lsu_req = bus.lsu_arvalid | bus.lsu_awvalid;
  assign aw_hs   = bus.lsu_awvalid && !aw_done_q && bus.awready;
  assign w_hs    = bus.lsu_wvalid && !w_done_q && bus.wready;

  assign wait_st   = (state_q == IFU_R) || (state_q == LSU_R) || (state_q == LSU_B);
  assign slv_valid = (state_q == LSU_B) ? bus.bvalid : bus.rvalid;

  always_comb begin
    own_ready = 1'b0;
    case (state_q)
      IFU_R:   own_ready = bus.ifu_rready;
      LSU_R:   own_ready = bus.lsu_rready;
      LSU_B:   own_ready = bus.lsu_bready;
      default: own_ready = 1'b0;
    endcase
  end

  axi_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (!wait_st),
    .enable_i (wait_st && !forced_q),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= MST_IFU;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      forced_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // With both requesting, whoever did not win last time goes first.
          if (lsu_req && (!ifu_req || (last_grant_q == MST_IFU))) begin
            last_grant_q <= MST_LSU;
            state_q      <= bus.lsu_awvalid ? LSU_W : LSU_AR;
          end else if (ifu_req) begin
            last_grant_q <= MST_IFU;
            state_q      <= IFU_AR;
          end
        end
        IFU_AR: if (bus.ifu_arvalid && bus.arready) state_q <= IFU_R;
        LSU_AR: if (bus.lsu_arvalid && bus.arready) state_q <= LSU_R;
        LSU_W: begin
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            state_q   <= LSU_B;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
          end
        end
        IFU_R, LSU_R, LSU_B: begin
          if (forced_q) begin
            if (own_ready) begin
              state_q  <= IDLE;
              forced_q <= 1'b0;
            end
          end else if (slv_valid && own_ready) begin
            state_q <= IDLE;
          end else if (wd_expire && !slv_valid) begin
            forced_q      <= 1'b1;
            timeout_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign timeout_err = timeout_err_q;

  always_comb begin
    bus.ifu_arready = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rresp   = RESP_OKAY;
    bus.ifu_rdata   = DATA_ZERO;
    bus.lsu_arready = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_rresp   = RESP_OKAY;
    bus.lsu_rdata   = DATA_ZERO;
    bus.lsu_awready = 1'b0;
    bus.lsu_wready  = 1'b0;
    bus.lsu_bvalid  = 1'b0;
    bus.lsu_bresp   = RESP_OKAY;
    bus.arvalid     = 1'b0;
    bus.araddr      = ADDR_ZERO;
    bus.rready      = 1'b0;
    bus.awvalid     = 1'b0;
    bus.awaddr      = ADDR_ZERO;
    bus.wvalid      = 1'b0;
    bus.wdata       = DATA_ZERO;
    bus.wstrb       = '0;
    bus.bready      = 1'b0;
    case (state_q)
      IDLE: begin
        // Idle sink swallows late responses left behind by a timed-out transaction.
        bus.rready = 1'b1;
        bus.bready = 1'b1;
      end
      IFU_AR: begin
        bus.arvalid     = bus.ifu_arvalid;
        bus.araddr      = bus.ifu_araddr;
        bus.ifu_arready = bus.arready;
      end
      LSU_AR: begin
        bus.arvalid     = bus.lsu_arvalid;
        bus.araddr      = bus.lsu_araddr;
        bus.lsu_arready = bus.arready;
      end
      IFU_R: begin
        if (forced_q) begin
          bus.ifu_rvalid = 1'b1;
          bus.ifu_rresp  = RESP_SLVERR;
        end else begin
          bus.ifu_rvalid = bus.rvalid;
          bus.ifu_rresp  = bus.rresp;
          bus.ifu_rdata  = bus.rdata;
          bus.rready     = bus.ifu_rready;
        end
      end
      LSU_R: begin
        if (forced_q) begin
          bus.lsu_rvalid = 1'b1;
          bus.lsu_rresp  = RESP_SLVERR;
        end else begin
          bus.lsu_rvalid = bus.rvalid;
          bus.lsu_rresp  = bus.rresp;
          bus.lsu_rdata  = bus.rdata;
          bus.rready     = bus.lsu_rready;
        end
      end
      LSU_W: begin
        bus.awvalid     = bus.lsu_awvalid && !aw_done_q;
        bus.awaddr      = bus.lsu_awaddr;
        bus.lsu_awready = bus.awready && !aw_done_q;
        bus.wvalid      = bus.lsu_wvalid && !w_done_q;
        bus.wdata       = bus.lsu_wdata;
        bus.wstrb       = bus.lsu_wstrb;
        bus.lsu_wready  = bus.wready && !w_done_q;
      end
      LSU_B: begin
        if (forced_q) begin
          bus.lsu_bvalid = 1'b1;
          bus.lsu_bresp  = RESP_SLVERR;
        end else begin
          bus.lsu_bvalid = bus.bvalid;
          bus.lsu_bresp  = bus.bresp;
          bus.bready     = bus.lsu_bready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: grant order, read/write forwarding, watchdog and async reset.
module tb_axi_arbiter;
  import axi_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  logic timeout_err;
  int   checks = 0;
  int   errors = 0;

  axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_arvalid = 0; bus.ifu_araddr = 0; bus.ifu_rready = 0;
    bus.lsu_arvalid = 0; bus.lsu_araddr = 0; bus.lsu_rready = 0;
    bus.lsu_awvalid = 0; bus.lsu_awaddr = 0; bus.lsu_wvalid = 0;
    bus.lsu_wdata = 0; bus.lsu_wstrb = 0; bus.lsu_bready = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.arvalid !== 1'b0 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin
      errors++; $display("FAIL reset_xbar_valid: got ar=%b aw=%b w=%b want 0", bus.arvalid, bus.awvalid, bus.wvalid);
    end
    checks++;
    if (bus.rready !== 1'b1 || bus.bready !== 1'b1) begin
      errors++; $display("FAIL reset_sink: got rready=%b bready=%b want 1 1", bus.rready, bus.bready);
    end
    checks++;
    if (bus.ifu_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0 || bus.lsu_bvalid !== 1'b0 ||
        bus.ifu_arready !== 1'b0 || timeout_err !== 1'b0 || bus.araddr !== 32'h0) begin
      errors++; $display("FAIL reset_master_side: got ifu_rv=%b lsu_rv=%b lsu_bv=%b ifu_ar=%b terr=%b araddr=%h want all 0",
                         bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_bvalid, bus.ifu_arready, timeout_err, bus.araddr);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_ifu_read();
    tick();
    bus.ifu_arvalid = 1; bus.ifu_araddr = 32'h3000_0000;
    #1;
    checks++;
    if (bus.arvalid !== 1'b0) begin
      errors++; $display("FAIL ifu_no_comb_ar: got arvalid=%b want 0", bus.arvalid);
    end
    tick();
    bus.arready = 1;
    #1;
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h3000_0000 || bus.ifu_arready !== 1'b1 || bus.lsu_arready !== 1'b0) begin
      errors++; $display("FAIL ifu_ar_fwd: got arvalid=%b araddr=%h ifu_ar=%b lsu_ar=%b want 1 30000000 1 0",
                         bus.arvalid, bus.araddr, bus.ifu_arready, bus.lsu_arready);
    end
    tick();
    bus.ifu_arvalid = 0; bus.arready = 0; bus.ifu_rready = 1;
    #1;
    checks++;
    if (bus.ifu_rvalid !== 1'b0 || bus.arvalid !== 1'b0) begin
      errors++; $display("FAIL ifu_r_wait: got ifu_rvalid=%b arvalid=%b want 0 0", bus.ifu_rvalid, bus.arvalid);
    end
    tick();
    tick();
    bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = RESP_OKAY;
    #1;
    checks++;
    if (bus.ifu_rvalid !== 1'b1 || bus.ifu_rdata !== 32'hDEAD_BEEF || bus.ifu_rresp !== 2'b00 ||
        bus.lsu_rvalid !== 1'b0 || bus.rready !== 1'b1) begin
      errors++; $display("FAIL ifu_r_fwd: got rv=%b rdata=%h rresp=%b lsu_rv=%b rready=%b want 1 deadbeef 00 0 1",
                         bus.ifu_rvalid, bus.ifu_rdata, bus.ifu_rresp, bus.lsu_rvalid, bus.rready);
    end
    tick();
    bus.rvalid = 0; bus.rdata = 0; bus.ifu_rready = 0;
    #1;
    checks++;
    if (bus.ifu_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0 || bus.rready !== 1'b1 || bus.ifu_rdata !== 32'h0) begin
      errors++; $display("FAIL ifu_back_idle: got ifu_rv=%b lsu_rv=%b rready=%b rdata=%h want 0 0 1 0",
                         bus.ifu_rvalid, bus.lsu_rvalid, bus.rready, bus.ifu_rdata);
    end
  endtask

  task automatic test_round_robin();
    tick();
    reset_n = 0; #2; reset_n = 1;
    tick();
    bus.ifu_arvalid = 1; bus.ifu_araddr = 32'h1000;
    bus.lsu_arvalid = 1; bus.lsu_araddr = 32'h2000;
    tick();
    bus.arready = 1;
    #1;
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h2000 || bus.lsu_arready !== 1'b1 || bus.ifu_arready !== 1'b0) begin
      errors++; $display("FAIL rr_first_lsu: got arvalid=%b araddr=%h lsu_ar=%b ifu_ar=%b want 1 2000 1 0",
                         bus.arvalid, bus.araddr, bus.lsu_arready, bus.ifu_arready);
    end
    tick();
    bus.lsu_arvalid = 0; bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h1111_1111; bus.lsu_rready = 1;
    #1;
    checks++;
    if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 32'h1111_1111 || bus.ifu_rvalid !== 1'b0 || bus.ifu_rdata !== 32'h0) begin
      errors++; $display("FAIL rr_lsu_owner: got lsu_rv=%b lsu_rdata=%h ifu_rv=%b ifu_rdata=%h want 1 11111111 0 0",
                         bus.lsu_rvalid, bus.lsu_rdata, bus.ifu_rvalid, bus.ifu_rdata);
    end
    tick();
    bus.rvalid = 0; bus.rdata = 0; bus.lsu_rready = 0;
    bus.lsu_arvalid = 1; bus.lsu_araddr = 32'h3000;
    #1;
    checks++;
    if (bus.arvalid !== 1'b0) begin
      errors++; $display("FAIL rr_idle_gap: got arvalid=%b want 0", bus.arvalid);
    end
    tick();
    bus.arready = 1;
    #1;
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1000) begin
      errors++; $display("FAIL rr_second_ifu: got arvalid=%b araddr=%h want 1 1000", bus.arvalid, bus.araddr);
    end
    tick();
    bus.ifu_arvalid = 0; bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h2222_2222; bus.ifu_rready = 1;
    #1;
    checks++;
    if (bus.ifu_rvalid !== 1'b1 || bus.ifu_rdata !== 32'h2222_2222 || bus.lsu_rvalid !== 1'b0) begin
      errors++; $display("FAIL rr_ifu_data: got ifu_rv=%b ifu_rdata=%h lsu_rv=%b want 1 22222222 0",
                         bus.ifu_rvalid, bus.ifu_rdata, bus.lsu_rvalid);
    end
    tick();
    bus.rvalid = 0; bus.rdata = 0; bus.ifu_rready = 0;
    tick();
    bus.arready = 1;
    #1;
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h3000 || bus.lsu_arready !== 1'b1) begin
      errors++; $display("FAIL rr_third_lsu: got arvalid=%b araddr=%h lsu_ar=%b want 1 3000 1",
                         bus.arvalid, bus.araddr, bus.lsu_arready);
    end
    tick();
    bus.lsu_arvalid = 0; bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h3333_3333; bus.lsu_rready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_write();
    tick();
    bus.lsu_awvalid = 1; bus.lsu_awaddr = 32'h0f00_0010;
    bus.lsu_wvalid = 1; bus.lsu_wdata = 32'h1234_5678; bus.lsu_wstrb = 4'b0011;
    tick();
    bus.wready = 1;
    #1;
    checks++;
    if (bus.awvalid !== 1'b1 || bus.awaddr !== 32'h0f00_0010 || bus.wvalid !== 1'b1 || bus.wdata !== 32'h1234_5678 ||
        bus.wstrb !== 4'b0011 || bus.lsu_wready !== 1'b1 || bus.lsu_awready !== 1'b0) begin
      errors++; $display("FAIL wr_fwd: got aw=%b awaddr=%h w=%b wdata=%h wstrb=%b lsu_wr=%b lsu_awr=%b want 1 0f000010 1 12345678 0011 1 0",
                         bus.awvalid, bus.awaddr, bus.wvalid, bus.wdata, bus.wstrb, bus.lsu_wready, bus.lsu_awready);
    end
    tick();
    #1;
    checks++;
    if (bus.wvalid !== 1'b0 || bus.lsu_wready !== 1'b0 || bus.awvalid !== 1'b1) begin
      errors++; $display("FAIL wr_w_masked: got wvalid=%b lsu_wready=%b awvalid=%b want 0 0 1",
                         bus.wvalid, bus.lsu_wready, bus.awvalid);
    end
    tick();
    tick();
    bus.awready = 1;
    #1;
    checks++;
    if (bus.lsu_awready !== 1'b1 || bus.awvalid !== 1'b1) begin
      errors++; $display("FAIL wr_aw_hs: got lsu_awready=%b awvalid=%b want 1 1", bus.lsu_awready, bus.awvalid);
    end
    tick();
    bus.lsu_awvalid = 0; bus.lsu_wvalid = 0; bus.awready = 0; bus.wready = 0;
    bus.bvalid = 1; bus.bresp = RESP_OKAY; bus.lsu_bready = 1;
    #1;
    checks++;
    if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.lsu_bvalid !== 1'b1 || bus.lsu_bresp !== 2'b00 || bus.bready !== 1'b1) begin
      errors++; $display("FAIL wr_b_fwd: got aw=%b w=%b lsu_bv=%b bresp=%b bready=%b want 0 0 1 00 1",
                         bus.awvalid, bus.wvalid, bus.lsu_bvalid, bus.lsu_bresp, bus.bready);
    end
    tick();
    bus.bvalid = 0; bus.lsu_bready = 0;
    #1;
    checks++;
    if (bus.lsu_bvalid !== 1'b0) begin
      errors++; $display("FAIL wr_b_once: got lsu_bvalid=%b want 0", bus.lsu_bvalid);
    end
  endtask

  task automatic test_write_before_read();
    tick();
    bus.lsu_awvalid = 1; bus.lsu_awaddr = 32'h44; bus.lsu_wvalid = 1; bus.lsu_wdata = 32'hCAFE_F00D; bus.lsu_wstrb = 4'hF;
    bus.lsu_arvalid = 1; bus.lsu_araddr = 32'h88;
    tick();
    bus.awready = 1; bus.wready = 1;
    #1;
    checks++;
    if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1 || bus.arvalid !== 1'b0 || bus.lsu_arready !== 1'b0) begin
      errors++; $display("FAIL wbr_write_first: got aw=%b w=%b ar=%b lsu_ar=%b want 1 1 0 0",
                         bus.awvalid, bus.wvalid, bus.arvalid, bus.lsu_arready);
    end
    tick();
    bus.lsu_awvalid = 0; bus.lsu_wvalid = 0; bus.awready = 0; bus.wready = 0;
    bus.bvalid = 1; bus.lsu_bready = 1;
    #1;
    checks++;
    if (bus.lsu_bvalid !== 1'b1 || bus.arvalid !== 1'b0) begin
      errors++; $display("FAIL wbr_same_cycle_b: got lsu_bvalid=%b arvalid=%b want 1 0", bus.lsu_bvalid, bus.arvalid);
    end
    tick();
    bus.bvalid = 0; bus.lsu_bready = 0;
    #1;
    checks++;
    if (bus.arvalid !== 1'b0) begin
      errors++; $display("FAIL wbr_idle_gap: got arvalid=%b want 0", bus.arvalid);
    end
    tick();
    bus.arready = 1;
    #1;
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h88) begin
      errors++; $display("FAIL wbr_read_after: got arvalid=%b araddr=%h want 1 88", bus.arvalid, bus.araddr);
    end
    tick();
    bus.lsu_arvalid = 0; bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h99; bus.lsu_rready = 1;
    #1;
    checks++;
    if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 32'h99) begin
      errors++; $display("FAIL wbr_read_data: got lsu_rvalid=%b lsu_rdata=%h want 1 99", bus.lsu_rvalid, bus.lsu_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    tick();
    bus.ifu_arvalid = 1; bus.ifu_araddr = 32'h40;
    tick();
    bus.arready = 1;
    tick();
    bus.ifu_arvalid = 0; bus.arready = 0; bus.ifu_rready = 1;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      #1;
      checks++;
      if (bus.ifu_rvalid !== 1'b0 || timeout_err !== 1'b0) begin
        errors++; $display("FAIL to_wait_c%0d: got ifu_rvalid=%b timeout_err=%b want 0 0", c, bus.ifu_rvalid, timeout_err);
      end
    end
    tick();
    #1;
    checks++;
    if (bus.ifu_rvalid !== 1'b1 || bus.ifu_rresp !== RESP_SLVERR || bus.ifu_rdata !== 32'h0 ||
        timeout_err !== 1'b1 || bus.lsu_rvalid !== 1'b0) begin
      errors++; $display("FAIL to_forced_err: got rv=%b rresp=%b rdata=%h terr=%b lsu_rv=%b want 1 10 0 1 0",
                         bus.ifu_rvalid, bus.ifu_rresp, bus.ifu_rdata, timeout_err, bus.lsu_rvalid);
    end
    tick();
    bus.rvalid = 1; bus.rdata = 32'hBADB_AD00;
    #1;
    checks++;
    if (bus.ifu_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0 || bus.rready !== 1'b1 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_stale_sink: got ifu_rv=%b lsu_rv=%b rready=%b terr=%b want 0 0 1 1",
                         bus.ifu_rvalid, bus.lsu_rvalid, bus.rready, timeout_err);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    tick();
    bus.lsu_awvalid = 1; bus.lsu_awaddr = 32'h0f00_0020; bus.lsu_wvalid = 1; bus.lsu_wdata = 32'h55; bus.lsu_wstrb = 4'hF;
    tick();
    bus.awready = 1;
    tick();
    bus.awready = 0;
    #1;
    checks++;
    if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_awdone: got awvalid=%b wvalid=%b want 0 1", bus.awvalid, bus.wvalid);
    end
    reset_n = 0;
    #1;
    checks++;
    if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.lsu_wready !== 1'b0 || bus.lsu_bvalid !== 1'b0 ||
        bus.rready !== 1'b1 || bus.bready !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL rst_async_drop: got aw=%b w=%b lsu_wr=%b lsu_bv=%b rready=%b bready=%b terr=%b want 0 0 0 0 1 1 0",
                         bus.awvalid, bus.wvalid, bus.lsu_wready, bus.lsu_bvalid, bus.rready, bus.bready, timeout_err);
    end
    clear_inputs();
    #2;
    reset_n = 1;
    tick();
    bus.lsu_awvalid = 1; bus.lsu_awaddr = 32'h50; bus.lsu_wvalid = 1; bus.lsu_wdata = 32'hA5A5_A5A5; bus.lsu_wstrb = 4'hF;
    tick();
    bus.awready = 1; bus.wready = 1;
    #1;
    checks++;
    if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1 || bus.awaddr !== 32'h50 || bus.wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL rst_fresh_write: got aw=%b w=%b awaddr=%h wdata=%h want 1 1 50 a5a5a5a5",
                         bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata);
    end
    tick();
    bus.lsu_awvalid = 0; bus.lsu_wvalid = 0; bus.awready = 0; bus.wready = 0;
    bus.bvalid = 1; bus.bresp = RESP_OKAY; bus.lsu_bready = 1;
    #1;
    checks++;
    if (bus.lsu_bvalid !== 1'b1 || bus.lsu_bresp !== 2'b00) begin
      errors++; $display("FAIL rst_fresh_b: got lsu_bvalid=%b bresp=%b want 1 00", bus.lsu_bvalid, bus.lsu_bresp);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.lsu_bvalid !== 1'b0 || bus.awvalid !== 1'b0) begin
      errors++; $display("FAIL rst_fresh_done: got lsu_bvalid=%b awvalid=%b want 0 0", bus.lsu_bvalid, bus.awvalid);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_write();
    test_write_before_read();
    test_timeout();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter, placed in front of the address-decoding crossbar.
- Masters: IFU (read-only, instruction fetch) and LSU (read and write, load/store).
- Grants exactly one outstanding transaction at a time, round-robin between IFU and LSU when both request.
- Forwards the granted master's channels to the crossbar upstream port and returns responses only to the owner; a watchdog converts a hung slave into an error response.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT, 1024, cycles allowed in a wait-for-response state before an error is forced; 0 disables the watchdog.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- ifu_arvalid / ifu_arready  in/out  1/1  IFU read-address handshake.
- ifu_araddr  in  ADDR_W  IFU read address.
- ifu_rvalid / ifu_rready  out/in  1/1  IFU read-data handshake.
- ifu_rresp / ifu_rdata  out/out  2/DATA_W  IFU read response and data.
- lsu_arvalid, lsu_araddr, lsu_arready, lsu_rvalid, lsu_rready, lsu_rresp, lsu_rdata  as IFU read group, LSU side.
- lsu_awvalid / lsu_awready / lsu_awaddr  in/out/in  1/1/ADDR_W  LSU write-address channel.
- lsu_wvalid / lsu_wready / lsu_wdata / lsu_wstrb  in/out/in/in  1/1/DATA_W/DATA_W/8  LSU write-data channel.
- lsu_bvalid / lsu_bready / lsu_bresp  out/in/out  1/1/2  LSU write-response channel.
- arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready  out  crossbar-side requests.
- arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp  in  crossbar-side responses.
- timeout_err  out  1  sticky flag; set on any watchdog expiry, cleared only by reset.

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B. Reset (async, any state, mid-transaction included) forces IDLE, clears last_grant to 0 (=IFU), aw_done, w_done, the watchdog counter and timeout_err.
- Reset output values: every valid/ready output is 0 except crossbar rready=1 and bready=1. These are the IDLE sink, which accepts and discards stale responses. Data/addr/resp outputs are 0.
- Request set in IDLE:
  - ifu_req = ifu_arvalid.
  - lsu_req = lsu_arvalid | lsu_awvalid.
  - Within LSU, a write (awvalid) beats a read if both are pending.
- Grant in IDLE:
  - Only one requester: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - last_grant updates on grant.
  - The state changes on the next edge, so the crossbar sees arvalid/awvalid one cycle after the master's valid. No combinational valid path exists in IDLE.
- Grant states:
  - All outputs are combinational muxes selected by state. The non-owner sees ready/valid = 0, data = 0.
  - Masters hold valid and payload until ready, per AXI.
- Read path:
  - X_AR forwards arvalid/araddr/arready. On handshake, go to X_R.
  - X_R forwards rvalid/rdata/rresp/rready. On rvalid&rready handshake, go to IDLE.
- Write path:
  - LSU_W forwards the AW and W channels concurrently, in either order.
  - aw_done/w_done latch their respective handshakes and mask that channel's valid once set.
  - When both are done (including same-cycle completion), go to LSU_B and clear the flags.
  - LSU_B forwards B. On handshake, go to IDLE.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to any state and counts while in X_R or LSU_B.
  - When it reaches TIMEOUT-1 with no response valid, the next cycle drives the owner rvalid/bvalid=1 with resp=2'b10 (SLVERR) and data 0, and sets timeout_err.
  - Once the master accepts, go to IDLE.
  - A slave response arriving in the same cycle as expiry takes priority and does not set timeout_err.
- No timeout applies in AR/W states; an unresponsive ready there is a system fault.
- Back-to-back operation: at least one IDLE cycle separates transactions. Throughput is at most one transaction per 3 cycles.

Decomposition:
- Shared package axi_pkg holds:
  - state enum (3 bits).
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - master index constants MST_IFU=0 and MST_LSU=1.
- Sub-module axi_arb_wdog: counter with clear/enable inputs and a TIMEOUT parameter, producing an expire pulse. This keeps the main FSM free of width arithmetic.

Test Plan:
- IFU-only read, araddr=0x30000000, slave rdata=0xDEADBEEF after 2 cycles -> crossbar arvalid rises 1 cycle after ifu_arvalid; ifu_rdata=0xDEADBEEF, rresp=0; lsu_rvalid stays 0.
- IFU and LSU read requested in the same cycle after reset -> LSU granted first (last_grant=IFU); the IFU AR is issued in the next IDLE; next simultaneous pair -> IFU first.
- LSU write awaddr=0x0f000010, wdata=0x12345678, wstrb=4'b0011, slave wready 3 cycles before awready -> wvalid masked after its handshake, a single AW is sent, lsu_bresp=0 returned once.
- LSU awvalid and arvalid both pending -> write is performed first; the read is granted only after B completes.
- TIMEOUT=8, IFU read with slave never asserting rvalid -> ifu_rvalid=1, rresp=2'b10, rdata=0 on the 9th cycle in IFU_R; timeout_err=1; a later stale rvalid in IDLE is consumed and not forwarded.
- reset_n pulled low while in LSU_W with aw_done=1 -> all master and crossbar valids drop immediately; state IDLE; flags cleared; a fresh write completes normally after release.
